// File: rtl/riscv_pipe_pkg.sv
// Shared RV32I pipeline definitions: opcodes, the canonical NOP and the
// hazard controller state encoding.
package riscv_pipe_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // add x0,x0,x0
  localparam logic [31:0] NOP_INST = 32'h00000033;

  typedef enum logic {
    RUN,
    LSTALL
  } hz_state_t;

endpackage

// File: rtl/rs_use_decode.sv
// Source-register usage decode from the major opcode. Shared by the hazard
// controller and the forwarding unit.
module rs_use_decode
  import riscv_pipe_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2
);

  // Classify the opcode by which register fields it actually reads.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        uses_rs1 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller for the 5-stage RV32I core: load-use stall
// insertion, redirect squash and external memory freeze. Outputs are Mealy.
// Optional performance counters (stall_cnt, flush_cnt) are built when
// HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl_unit
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned LOAD_USE_STALL = 1,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             ext_stall,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic             stall_active,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`else
  output logic             stall_active
`endif
);

  hz_state_t  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       uses_rs1, uses_rs2;
  logic       hazard;
  logic       lu_bubble;

  rs_use_decode u_rs_use_decode (
    .opcode   (id_inst[6:0]),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // Funct/rd/imm fields play no part in hazard detection.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

  assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (id_inst[19:15] == ex_rd)) ||
                   (uses_rs2 && (id_inst[24:20] == ex_rd)));

  // Next-state and pipeline control in priority order.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    stall_active = (state_q == LSTALL);
    lu_bubble    = 1'b0;
    if (rst) begin
      state_d      = RUN;
      cnt_d        = '0;
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      stall_active = 1'b0;
    end else if (ext_stall) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      cnt_d       = '0;
    end else if (state_q == LSTALL) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      lu_bubble   = 1'b1;
      // cnt counts the bubbles still owed, including this cycle's.
      if (cnt_q <= 2'd1) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (hazard) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      lu_bubble   = 1'b1;
      if (LOAD_USE_STALL > 1) begin
        state_d = LSTALL;
        cnt_d   = 2'(LOAD_USE_STALL - 1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters, frozen along with the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!ext_stall) begin
      if (lu_bubble && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ifid_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  logic             unused_lu_bubble;
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_lu_bubble = lu_bubble;
  assign unused_cnt_w     = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench: two controllers (LOAD_USE_STALL=1 and =2) share one
// stimulus stream; a reference model pushes expected outputs into a per-DUT
// scoreboard queue which is popped and compared mid-cycle.
module tb_hazard_ctrl_unit;
  import riscv_pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ex_is_load, ex_redirect, ext_stall;
  logic [31:0] id_inst;
  logic [4:0]  ex_rd;
  logic [1:0]  pc_en, ifid_en, ifid_flush, idex_bubble, stall_active;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt [2];
  logic [31:0] flush_cnt [2];
`endif

  hazard_ctrl_unit #(.LOAD_USE_STALL(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .rst(rst), .id_inst(id_inst), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .ifid_flush(ifid_flush[0]),
    .idex_bubble(idex_bubble[0]),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0]),
`endif
    .stall_active(stall_active[0])
  );

  hazard_ctrl_unit #(.LOAD_USE_STALL(2), .CNT_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .id_inst(id_inst), .ex_is_load(ex_is_load),
    .ex_rd(ex_rd), .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .ifid_flush(ifid_flush[1]),
    .idex_bubble(idex_bubble[1]),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1]),
`endif
    .stall_active(stall_active[1])
  );

  typedef struct packed {
    logic [4:0]  sig;   // {pc_en, ifid_en, ifid_flush, idex_bubble, stall_active}
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int total = 0;
  int bad   = 0;

  // Reference state: bubbles still owed after the detecting cycle.
  int          rem   [2] = '{0, 0};
  int          rem_n [2];
  int unsigned sc_m  [2] = '{0, 0};
  int unsigned fc_m  [2] = '{0, 0};

  localparam logic [31:0] ADD_X6    = {7'd0, 5'd2, 5'd5, 3'd0, 5'd6, OP_R};
  localparam logic [31:0] ADDI_X7   = {12'd1, 5'd0, 3'd0, 5'd7, OP_IMM};
  localparam logic [31:0] LUI_X5    = {7'd0, 5'd5, 5'd5, 3'd0, 5'd5, OP_LUI};
  localparam logic [31:0] ADDI_IMM5 = {7'd0, 5'd5, 5'd1, 3'd0, 5'd6, OP_IMM};
  localparam logic [31:0] SW_X5     = {7'd0, 5'd5, 5'd1, 3'b010, 5'd0, OP_STORE};
  localparam logic [31:0] BEQ_X5    = {7'd0, 5'd5, 5'd1, 3'd0, 5'd0, OP_BRANCH};
  localparam logic [31:0] JALR_X5   = {12'd0, 5'd5, 3'd0, 5'd1, OP_JALR};
  localparam logic [31:0] LW_DEP    = {12'd0, 5'd5, 3'b010, 5'd8, OP_LOAD};
  localparam logic [31:0] JAL_F5    = {7'd0, 5'd5, 5'd5, 3'd0, 5'd1, OP_JAL};
  localparam logic [31:0] AUIPC_F5  = {7'd0, 5'd5, 5'd5, 3'd0, 5'd5, OP_AUIPC};

  logic [31:0] inst_tab [11] = '{ADD_X6, ADDI_X7, LUI_X5, ADDI_IMM5, SW_X5,
                                 BEQ_X5, JALR_X5, LW_DEP, JAL_F5, AUIPC_F5,
                                 NOP_INST};

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit ref_hazard(input logic [31:0] inst, input logic ld,
                                    input logic [4:0] rd);
    bit r1, r2;
    r1 = 1'b0;
    r2 = 1'b0;
    case (inst[6:0])
      OP_R, OP_STORE, OP_BRANCH: begin r1 = 1'b1; r2 = 1'b1; end
      OP_IMM, OP_LOAD, OP_JALR:  r1 = 1'b1;
      default: ;
    endcase
    return ld && (rd != 5'd0) &&
           ((r1 && inst[19:15] == rd) || (r2 && inst[24:20] == rd));
  endfunction

  // One clock cycle: drive, predict, compare at the falling edge.
  task automatic step(input logic r, input logic e, input logic x,
                      input logic ld, input logic [4:0] rd,
                      input logic [31:0] inst, input string tag);
    bit   hz, lu;
    logic pe, ie, fl, bb, sa;
    exp_t ex, got_e;
    rst = r; ext_stall = e; ex_redirect = x; ex_is_load = ld;
    ex_rd = rd; id_inst = inst;
    hz = ref_hazard(inst, ld, rd);
    for (int i = 0; i < 2; i++) begin
      lu = 1'b0;
      rem_n[i] = rem[i];
      sa = !r && (rem[i] > 0);
      if (r) begin
        {pe, ie, fl, bb} = 4'b0011; rem_n[i] = 0;
      end else if (e) begin
        {pe, ie, fl, bb} = 4'b0000;
      end else if (x) begin
        {pe, ie, fl, bb} = 4'b1111; rem_n[i] = 0;
      end else if (rem[i] > 0) begin
        {pe, ie, fl, bb} = 4'b0001; lu = 1'b1; rem_n[i] = rem[i] - 1;
      end else if (hz) begin
        {pe, ie, fl, bb} = 4'b0001; lu = 1'b1; rem_n[i] = i;
      end else begin
        {pe, ie, fl, bb} = 4'b1100;
      end
      ex.sig = {pe, ie, fl, bb, sa};
      ex.sc  = sc_m[i];
      ex.fc  = fc_m[i];
      if (i == 0) sb0.push_back(ex); else sb1.push_back(ex);
      if (r) begin
        sc_m[i] = 0; fc_m[i] = 0;
      end else if (!e) begin
        if (lu && sc_m[i] != 32'hffffffff) sc_m[i]++;
        if (fl && fc_m[i] != 32'hffffffff) fc_m[i]++;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) got_e = sb0.pop_front(); else got_e = sb1.pop_front();
      check_val($sformatf("%s/L%0d", tag, i + 1),
                64'({pc_en[i], ifid_en[i], ifid_flush[i], idex_bubble[i],
                     stall_active[i]}), 64'(got_e.sig));
`ifdef HAZARD_PERF_CNT_EN
      check_val($sformatf("%s/L%0d/stall_cnt", tag, i + 1),
                64'(stall_cnt[i]), 64'(got_e.sc));
      check_val($sformatf("%s/L%0d/flush_cnt", tag, i + 1),
                64'(flush_cnt[i]), 64'(got_e.fc));
`endif
      rem[i] = rem_n[i];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ext_stall = 1'b0; ex_redirect = 1'b0; ex_is_load = 1'b0;
    ex_rd = '0; id_inst = NOP_INST;

    step(1, 0, 0, 0, 5'd0, NOP_INST, "reset0");
    step(1, 0, 0, 0, 5'd0, NOP_INST, "reset1");
    step(0, 0, 0, 0, 5'd0, NOP_INST, "idle");

    // Load-use: lw x5 in EX, add x6,x5,x2 in ID; EX then holds a bubble.
    step(0, 0, 0, 1, 5'd5, ADD_X6, "lu_det");
    step(0, 0, 0, 0, 5'd5, ADD_X6, "lu_c1");
    step(0, 0, 0, 0, 5'd5, ADD_X6, "lu_c2");
    step(0, 0, 0, 0, 5'd0, NOP_INST, "lu_c3");

    // Cases that must not stall.
    step(0, 0, 0, 1, 5'd0, ADDI_X7, "rd0");
    step(0, 0, 0, 1, 5'd0, ADD_X6, "rd0_add");
    step(0, 0, 0, 1, 5'd5, LUI_X5, "lui");
    step(0, 0, 0, 1, 5'd5, ADDI_IMM5, "imm_rs2f");
    step(0, 0, 0, 1, 5'd5, JAL_F5, "jal");
    step(0, 0, 0, 1, 5'd5, AUIPC_F5, "auipc");
    step(0, 0, 0, 0, 5'd5, ADD_X6, "no_load");

    // Redirect during the second stall cycle.
    step(0, 0, 0, 1, 5'd5, ADD_X6, "rd_det");
    step(0, 0, 1, 0, 5'd5, ADD_X6, "rd_redir");
    step(0, 0, 0, 0, 5'd5, ADD_X6, "rd_after1");
    step(0, 0, 0, 0, 5'd5, ADD_X6, "rd_after2");

    // External stall held three cycles inside LSTALL.
    step(0, 0, 0, 1, 5'd5, ADD_X6, "es_det");
    for (int k = 0; k < 3; k++) step(0, 1, 0, 0, 5'd5, ADD_X6, "es_hold");
    step(0, 0, 0, 0, 5'd5, ADD_X6, "es_rel1");
    step(0, 0, 0, 0, 5'd5, ADD_X6, "es_rel2");
    step(0, 0, 0, 0, 5'd5, ADD_X6, "es_rel3");

    // Redirect pending under ext_stall.
    step(0, 0, 0, 1, 5'd5, ADD_X6, "ep_det");
    step(0, 1, 1, 0, 5'd5, ADD_X6, "ep_hold1");
    step(0, 1, 1, 0, 5'd5, ADD_X6, "ep_hold2");
    step(0, 0, 1, 0, 5'd5, ADD_X6, "ep_redir");
    step(0, 0, 0, 0, 5'd5, ADD_X6, "ep_after");

    // Reset in the middle of a stall.
    step(0, 0, 0, 1, 5'd5, ADD_X6, "rs_det");
    step(1, 0, 0, 0, 5'd5, ADD_X6, "rs_rst");
    step(0, 0, 0, 0, 5'd5, ADD_X6, "rs_after1");
    step(0, 0, 0, 0, 5'd5, ADD_X6, "rs_after2");

    // Other consumers of x5, including a dependent load.
    for (int k = 4; k < 8; k++) begin
      step(0, 0, 0, 1, 5'd5, inst_tab[k], $sformatf("use%0d_det", k));
      step(0, 0, 0, 0, 5'd5, inst_tab[k], $sformatf("use%0d_c1", k));
      step(0, 0, 0, 0, 5'd5, inst_tab[k], $sformatf("use%0d_c2", k));
    end

    // Hazard held during LSTALL is ignored.
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 5'd5, ADD_X6, "held");
    step(0, 0, 0, 0, 5'd0, NOP_INST, "held_end");

    // Random traffic.
    for (int k = 0; k < 300; k++) begin
      step(($urandom % 25) == 0, ($urandom % 6) == 0, ($urandom % 8) == 0,
           1'($urandom % 2), 5'($urandom % 8),
           inst_tab[$urandom % 11], "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Pipeline hazard controller for the 5-stage RV32I core; it sequences PC, IF/ID and ID/EX pipeline-register control.
- Detects load-use hazards between the ID and EX stages and holds fetch/decode for a parameterised number of bubble cycles.
- Squashes wrong-path instructions on taken branches and jumps resolved in EX, and freezes the pipeline on an external memory stall.
- Replaces the ad-hoc hazard logic inside instruction memory; the instruction memory becomes a pure storage/fetch block.

Parameters:
- LOAD_USE_STALL, 1, bubbles inserted per load-use hazard. 1 when MEM-to-EX forwarding exists; 2 without forwarding. Legal range 1..3.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- id_inst  input  32  instruction currently in ID
- ex_is_load  input  1  EX stage holds a load (opcode 0000011)
- ex_rd  input  5  destination register of the EX instruction
- ex_redirect  input  1  EX resolved a taken branch, JAL or JALR this cycle
- ext_stall  input  1  memory busy; freeze the whole pipeline
- pc_en  output  1  PC register update enable
- ifid_en  output  1  IF/ID register load enable
- ifid_flush  output  1  load NOP (32'h00000033) into IF/ID
- idex_bubble  output  1  load NOP/zero control into ID/EX
- stall_active  output  1  high while the FSM is in LSTALL

Behaviour:
- Source-use decode on id_inst[6:0]:
  - 0110011, 0100011, 1100011 use rs1 and rs2.
  - 0010011, 0000011, 1100111 use rs1 only.
  - 0110111, 0010111, 1101111 and all others use no source register.
- hazard = ex_is_load & (ex_rd != 0) & ((uses_rs1 & rs1 == ex_rd) | (uses_rs2 & rs2 == ex_rd)).
- State: enum {RUN, LSTALL}, plus a 2-bit down-counter cnt. Outputs are Mealy (combinational from state and inputs), so there is zero-cycle response. State updates on posedge clk.
- Evaluation priority per cycle is rst > ext_stall > ex_redirect > LSTALL > hazard > normal.
  - rst=1: next state RUN, cnt=0. Outputs pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, stall_active=0.
  - ext_stall=1: pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0. State and cnt hold. A pending ex_redirect is acted on in the first cycle ext_stall=0; the EX stage is frozen, so the redirect stays asserted.
  - ex_redirect=1: ifid_flush=1, idex_bubble=1, pc_en=1, ifid_en=1. Next state RUN, cnt=0. This aborts any LSTALL in progress; the stalled instruction is wrong-path.
  - State LSTALL: pc_en=0, ifid_en=0, idex_bubble=1, stall_active=1. The hazard term is ignored. cnt decrements each cycle; when cnt==1, next state is RUN.
  - State RUN with hazard=1: pc_en=0, ifid_en=0, idex_bubble=1. If LOAD_USE_STALL>1, next state is LSTALL with cnt=LOAD_USE_STALL-1; otherwise the FSM stays in RUN.
  - Otherwise: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- Total bubble count per load-use hazard equals LOAD_USE_STALL exactly. After the last bubble, the dependent instruction issues and no re-detection occurs, because EX now holds a bubble.
- Back-to-back loads (load, then a dependent load) are handled as an ordinary hazard on the second load's rs1.
- Reset mid-LSTALL returns the FSM to RUN in the same edge with no residual bubble.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0].
  - stall_cnt increments each cycle idex_bubble=1 due to a load-use hazard (not a redirect).
  - flush_cnt increments each cycle ifid_flush=1 outside reset.
  - Both counters saturate at all-ones, are cleared by rst, and hold during ext_stall.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package riscv_pipe_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - NOP_INST = 32'h00000033;
  - the hz_state_t enum.
- One combinational sub-module, rs_use_decode: input opcode, outputs uses_rs1 and uses_rs2. It is reused by the forwarding unit.

Test Plan:
- lw x5,0(x1) in EX (ex_rd=5) with id_inst=add x6,x5,x2, LOAD_USE_STALL=1 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then normal flow.
- Same stimulus with LOAD_USE_STALL=2 -> two bubble cycles and stall_active=1 in the second cycle; RUN on the third cycle.
- Load to ex_rd=0 with id_inst=addi x7,x0,1 -> no stall. Load x5 with id_inst=lui x5 -> no stall.
- ex_redirect=1 during the second LSTALL cycle -> ifid_flush=1, idex_bubble=1, pc_en=1 that cycle; next cycle RUN with no further bubbles.
- ext_stall=1 for 3 cycles while in LSTALL with cnt=1 -> all enables 0 and state held; after release, exactly one remaining bubble.
- rst asserted mid-LSTALL -> ifid_flush=1 and idex_bubble=1 during reset. After release: RUN, and with HAZARD_PERF_CNT_EN, stall_cnt=0 and flush_cnt=0.
